// File: rtl/jtdsp16_yaau.sv
// Y-space address unit: r0-r3/j/k/rb/re register file, loads and pointer post-modify; 1-cycle update, always ready.
// Optional circular-buffer wrap (rY==re -> rb on +1) enabled by `define JTDSP16_YAAU_VSR_EN.
module jtdsp16_yaau #(
    parameter int DW     = 16,
    parameter int RAM_AW = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cen,
    input  logic [2:0]        r_field,
    input  logic [1:0]        y_field,
    input  logic              short_load,
    input  logic              long_load,
    input  logic              ram_load,
    input  logic              acc_load,
    input  logic              post_load,
    input  logic [1:0]        inc_sel,
    input  logic              step_sel,
    input  logic              ksel,
    input  logic [8:0]        short_imm,
    input  logic [DW-1:0]     long_imm,
    input  logic [DW-1:0]     ram_dout,
    input  logic [DW-1:0]     acc_dout,
    input  logic [2:0]        rd_sel,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [DW-1:0]     rd_data
);

    logic [DW-1:0] r [4];
    logic [DW-1:0] j, k, rb, re;

    logic [DW-1:0] ry;
    logic [DW-1:0] step;
    logic [DW-1:0] ry_next;
    logic [DW-1:0] short_ext;
    logic [DW-1:0] load_val;
    logic          load;

    // j and k are signed step values, so short immediates are sign-extended only for them
    always_comb begin
        short_ext = {{(DW-9){1'b0}}, short_imm};
        if (r_field[2:1] == 2'b11)
            short_ext = {{(DW-9){short_imm[8]}}, short_imm};
    end

    always_comb begin
        load_val = acc_dout;
        if (long_load)       load_val = long_imm;
        else if (short_load) load_val = short_ext;
        else if (ram_load)   load_val = ram_dout;
    end

    assign load = long_load | short_load | ram_load | acc_load;

    always_comb begin
        ry   = r[y_field];
        step = '0;
        if (step_sel) begin
            step = ksel ? k : j;
        end else begin
            case (inc_sel)
                2'd1:    step = DW'(1);
                2'd2:    step = '1;
                default: step = '0;
            endcase
        end
        ry_next = ry + step;
`ifdef JTDSP16_YAAU_VSR_EN
        if (!step_sel && inc_sel == 2'd1 && re != '0 && ry == re)
            ry_next = rb;
`endif
    end

    // The load is assigned last so it overrides a post-modify of the same register
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) r[i] <= '0;
            j  <= '0;
            k  <= '0;
            rb <= '0;
            re <= '0;
        end else if (cen) begin
            if (post_load)
                r[y_field] <= ry_next;
            if (load) begin
                case (r_field)
                    3'd4:    rb <= load_val;
                    3'd5:    re <= load_val;
                    3'd6:    j  <= load_val;
                    3'd7:    k  <= load_val;
                    default: r[r_field[1:0]] <= load_val;
                endcase
            end
        end
    end

    assign ram_addr = ry[RAM_AW-1:0];

    always_comb begin
        case (rd_sel)
            3'd4:    rd_data = rb;
            3'd5:    rd_data = re;
            3'd6:    rd_data = j;
            3'd7:    rd_data = k;
            default: rd_data = r[rd_sel[1:0]];
        endcase
    end

endmodule
